// File: rtl/fft_ctrl_pkg.sv
// Shared types and helpers for the parametrised FFT address sequencer.
package fft_ctrl_pkg;

   typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

   localparam int DEF_LOG2_N   = 11;
   localparam int DEF_PIPE_LAT = 5;

   function automatic int num_stages(input int log2_n);
      return log2_n / 2 + log2_n % 2;
   endfunction

   // Digit-sum bank map; odd sizes shift the digit grid up one bit and fold bit 0 in as weight 2.
   function automatic logic [1:0] bank_of(input logic [13:0] index, input int log2_n);
      logic [13:0] sh;
      logic [1:0]  sum;
      sh  = (log2_n % 2 == 1) ? (index >> 1) : index;
      sum = 2'd0;
      for (int k = 0; k < 7; k++) begin
         sum = sum + sh[2*k +: 2];
      end
      if ((log2_n % 2 == 1) && index[0]) begin
         sum = sum + 2'd2;
      end
      return sum;
   endfunction

endpackage

// File: rtl/fft_ctrl_delay.sv
// Fixed-depth shift register carrying the read-side bus to the write ports.
module fft_ctrl_delay #(
   parameter int DEPTH = 5,
   parameter int W     = 1
) (
   input  logic         iCLK,
   input  logic         iRESET,
   input  logic         flush,
   input  logic [W-1:0] shift_data,
   output logic [W-1:0] delayed_data
);

   logic [W-1:0] tap [0:DEPTH];

   assign tap[0] = shift_data;

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [W-1:0] data_reg;
      always_ff @(posedge iCLK) begin
         if (!iRESET || flush) begin
            data_reg <= '0;
         end else begin
            data_reg <= tap[gi];
         end
      end
      assign tap[gi+1] = data_reg;
   end

   assign delayed_data = tap[DEPTH];

endmodule

// File: rtl/fft_ctrl_param.sv
// Mixed radix-4/radix-2 in-place FFT sequencer: per-leg bank addresses, twiddle index, write-back timing.
module fft_ctrl_param
   import fft_ctrl_pkg::*;
#(
   parameter int LOG2_N   = DEF_LOG2_N,
   parameter int PIPE_LAT = DEF_PIPE_LAT
) (
   input  logic                      iCLK,
   input  logic                      iRESET,
   input  logic                      iSTART,
   input  logic                      iABORT,
   input  logic                      iINVERSE,
   output logic                      oRD_EN,
   output logic [4*(LOG2_N-2)-1:0]   oADDR_RD,
   output logic [7:0]                oBANK_RD,
   output logic                      oWR_EN,
   output logic [4*(LOG2_N-2)-1:0]   oADDR_WR,
   output logic [7:0]                oBANK_WR,
   output logic [LOG2_N-3:0]         oADDR_COEF,
   output logic                      oBUT_TYPE,
   output logic [3:0]                oSTAGE,
   output logic                      oCONJ,
   output logic                      oRDY,
   output logic                      oDONE
);

   localparam int A      = LOG2_N - 2;
   localparam int STAGES = num_stages(LOG2_N);
   localparam int R4     = LOG2_N / 2;
   localparam int WR_W   = 1 + 4*A + 8;
   // The final gap is one cycle longer so oDONE follows the registered outputs.
   localparam logic [4:0] GAP_END  = 5'(PIPE_LAT);
   localparam logic [4:0] GAP_LAST = 5'(PIPE_LAT + 1);

   typedef logic [LOG2_N-1:0] idx_t;

   state_t       state_reg, state_next;
   logic [A-1:0] b_reg, b_next;
   logic [3:0]   stage_reg, stage_next;
   logic [4:0]   gap_reg, gap_next;
   logic         conj_reg, conj_next;
   logic         done_next, done_reg;
   logic         accept, kill, last_stage, is_r2;
   logic [4:0]   gap_limit;

   assign accept     = (state_reg == IDLE) && iSTART && !iABORT;
   assign kill       = (state_reg != IDLE) && iABORT;
   assign last_stage = (stage_reg == 4'(STAGES - 1));
   assign gap_limit  = last_stage ? GAP_LAST : GAP_END;
   assign is_r2      = (LOG2_N % 2 == 1) && (stage_reg == 4'(R4));

   always_comb begin
      state_next = state_reg;
      b_next     = b_reg;
      stage_next = stage_reg;
      gap_next   = gap_reg;
      conj_next  = conj_reg;
      done_next  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               state_next = RUN;
               b_next     = '0;
               stage_next = 4'd0;
               conj_next  = iINVERSE;
            end
         end
         RUN: begin
            if (b_reg == '1) begin
               state_next = GAP;
               gap_next   = 5'd0;
            end else begin
               b_next = b_reg + 1'b1;
            end
         end
         GAP: begin
            if (gap_reg == gap_limit) begin
               if (last_stage) begin
                  state_next = IDLE;
                  done_next  = 1'b1;
               end else begin
                  state_next = RUN;
                  stage_next = stage_reg + 4'd1;
                  b_next     = '0;
               end
            end else begin
               gap_next = gap_reg + 5'd1;
            end
         end
         default: state_next = IDLE;
      endcase
      if (kill) begin
         state_next = IDLE;
         done_next  = 1'b0;
      end
   end

   always_ff @(posedge iCLK) begin
      if (!iRESET) begin
         state_reg <= IDLE;
         b_reg     <= '0;
         stage_reg <= 4'd0;
         gap_reg   <= 5'd0;
         conj_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         b_reg     <= b_next;
         stage_reg <= stage_next;
         gap_reg   <= gap_next;
         conj_reg  <= conj_next;
      end
   end

   // Radix-4 index: insert two zero bits at the span position of b, then OR in the leg number.
   logic [3:0]     span_sh;
   idx_t           b_ext, low_bits, base;
   idx_t           leg_idx [4];
   logic [4*A-1:0] addr_next;
   logic [7:0]     bank_next;
   logic [A-1:0]   coef_next;

   assign span_sh   = is_r2 ? 4'd0 : 4'(A - 2*int'(stage_reg));
   assign b_ext     = idx_t'(b_reg);
   assign low_bits  = b_ext & ((idx_t'(1) << span_sh) - idx_t'(1));
   assign base      = ((b_ext >> span_sh) << (span_sh + 4'd2)) | low_bits;
   assign coef_next = is_r2 ? '0 : A'(low_bits << {stage_reg, 1'b0});

   for (genvar gi = 0; gi < 4; gi++) begin : g_leg
      assign leg_idx[gi] = is_r2 ? {b_reg, 2'(gi)} : (base | (idx_t'(gi) << span_sh));
      assign addr_next[gi*A +: A]  = leg_idx[gi][LOG2_N-1:2];
      assign bank_next[2*gi +: 2]  = bank_of(14'(leg_idx[gi]), LOG2_N);
   end

   logic           rd_en_reg, but_type_reg;
   logic [4*A-1:0] addr_rd_reg;
   logic [7:0]     bank_rd_reg;
   logic [A-1:0]   coef_reg;
   logic [3:0]     stage_out_reg;

   always_ff @(posedge iCLK) begin
      if (!iRESET) begin
         rd_en_reg     <= 1'b0;
         addr_rd_reg   <= '0;
         bank_rd_reg   <= '0;
         coef_reg      <= '0;
         but_type_reg  <= 1'b0;
         stage_out_reg <= 4'd0;
         done_reg      <= 1'b0;
      end else begin
         rd_en_reg <= (state_reg == RUN) && !iABORT;
         done_reg  <= done_next;
         if (state_reg == RUN) begin
            addr_rd_reg   <= addr_next;
            bank_rd_reg   <= bank_next;
            coef_reg      <= coef_next;
            but_type_reg  <= is_r2;
            stage_out_reg <= stage_reg;
         end
      end
   end

   logic [WR_W-1:0] wr_bus;

   fft_ctrl_delay #(
      .DEPTH (PIPE_LAT),
      .W     (WR_W)
   ) u_delay (
      .iCLK         (iCLK),
      .iRESET       (iRESET),
      .flush        (kill),
      .shift_data   ({rd_en_reg, addr_rd_reg, bank_rd_reg}),
      .delayed_data (wr_bus)
   );

   assign {oWR_EN, oADDR_WR, oBANK_WR} = wr_bus;
   assign oRD_EN     = rd_en_reg;
   assign oADDR_RD   = addr_rd_reg;
   assign oBANK_RD   = bank_rd_reg;
   assign oADDR_COEF = coef_reg;
   assign oBUT_TYPE  = but_type_reg;
   assign oSTAGE     = stage_out_reg;
   assign oCONJ      = conj_reg;
   assign oRDY       = (state_reg == IDLE);
   assign oDONE      = done_reg;

endmodule

// File: tb/tb_fft_ctrl_param.sv
// Three sequencer sizes (N=16, 32, 2048) checked cycle by cycle against an index-formula model.
module tb_fft_ctrl_param;

   localparam int PL = 5;
   localparam int NI = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic start_i [NI];
   logic abort_i [NI];
   logic inv_i   [NI];

   logic        o_rd_en [NI], o_wr_en [NI], o_bt [NI], o_conj [NI], o_rdy [NI], o_done [NI];
   logic [63:0] o_addr_rd [NI], o_addr_wr [NI];
   logic [7:0]  o_bank_rd [NI], o_bank_wr [NI];
   logic [15:0] o_coef [NI];
   logic [3:0]  o_stage [NI];

   for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      localparam int L = (gi == 0) ? 4 : ((gi == 1) ? 5 : 11);
      localparam int A = L - 2;
      logic [4*A-1:0] addr_rd, addr_wr;
      logic [A-1:0]   coef;
      fft_ctrl_param #(.LOG2_N(L), .PIPE_LAT(PL)) u_dut (
         .iCLK       (clk),
         .iRESET     (rst_n),
         .iSTART     (start_i[gi]),
         .iABORT     (abort_i[gi]),
         .iINVERSE   (inv_i[gi]),
         .oRD_EN     (o_rd_en[gi]),
         .oADDR_RD   (addr_rd),
         .oBANK_RD   (o_bank_rd[gi]),
         .oWR_EN     (o_wr_en[gi]),
         .oADDR_WR   (addr_wr),
         .oBANK_WR   (o_bank_wr[gi]),
         .oADDR_COEF (coef),
         .oBUT_TYPE  (o_bt[gi]),
         .oSTAGE     (o_stage[gi]),
         .oCONJ      (o_conj[gi]),
         .oRDY       (o_rdy[gi]),
         .oDONE      (o_done[gi])
      );
      assign o_addr_rd[gi] = 64'(addr_rd);
      assign o_addr_wr[gi] = 64'(addr_wr);
      assign o_coef[gi]    = 16'(coef);
   end

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input int g, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s inst %0d @%0t: got %0h expected %0h", tag, g, $time, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic        en;
      logic [63:0] addr;
      logic [7:0]  bank;
      logic [15:0] coef;
      logic        bt;
      logic [3:0]  stage;
   } rd_exp_t;

   function automatic int ln_of(input int g);
      return (g == 0) ? 4 : ((g == 1) ? 5 : 11);
   endfunction

   function automatic int total_of(input int l);
      return (l/2 + l%2) * ((1 << (l-2)) + PL + 1) + 1;
   endfunction

   function automatic int lat_ref(input int g);
      return (g == 0) ? 21 : ((g == 1) ? 43 : 3109);
   endfunction

   function automatic int bank_ref(input int idx, input int l);
      int c;
      int sum;
      c   = l % 2;
      sum = 0;
      for (int k = 0; 2*k + c + 1 <= l - 1; k++) sum += (idx >> (2*k + c)) & 3;
      sum += 2 * c * (idx & 1);
      return sum % 4;
   endfunction

   // Expected read-side outputs t cycles after the accepted start edge.
   function automatic rd_exp_t model_rd(input int l, input int t);
      rd_exp_t e;
      int n4, a, r4, st, tt, u, s, b, sp, base, idx;
      e  = '0;
      n4 = 1 << (l - 2);
      a  = l - 2;
      r4 = l / 2;
      st = r4 + l % 2;
      tt = n4 + PL + 1;
      u  = t - 1;
      if (u < 0) return e;
      s = u / tt;
      b = u % tt;
      if (s >= st || b >= n4) return e;
      e.en    = 1'b1;
      e.stage = 4'(s);
      sp      = (s < r4) ? (1 << (l - 2 - 2*s)) : 1;
      for (int m = 0; m < 4; m++) begin
         if (s < r4) begin
            base = (b / sp) * 4 * sp + b % sp;
            idx  = base + m * sp;
         end else begin
            idx = 4 * b + m;
         end
         e.addr = e.addr | (64'(idx / 4) << (m * a));
         e.bank = e.bank | (8'(bank_ref(idx, l)) << (2 * m));
      end
      if (s < r4) begin
         e.coef = 16'((b % sp) * (1 << (2 * s)));
         e.bt   = 1'b0;
      end else begin
         e.coef = 16'd0;
         e.bt   = 1'b1;
      end
      return e;
   endfunction

   logic busy_m [NI];
   int   t_m    [NI];
   logic conj_m [NI];
   logic done_m [NI];
   logic zero_m [NI];

   always @(posedge clk) begin
      for (int g = 0; g < NI; g++) begin
         done_m[g] <= 1'b0;
         if (!rst_n) begin
            busy_m[g] <= 1'b0;
            t_m[g]    <= 0;
            conj_m[g] <= 1'b0;
            zero_m[g] <= 1'b1;
         end else if (busy_m[g]) begin
            if (abort_i[g]) begin
               busy_m[g] <= 1'b0;
            end else begin
               t_m[g] <= t_m[g] + 1;
               if (t_m[g] + 1 == total_of(ln_of(g))) begin
                  busy_m[g] <= 1'b0;
                  done_m[g] <= 1'b1;
               end
            end
         end else if (start_i[g] && !abort_i[g]) begin
            busy_m[g] <= 1'b1;
            t_m[g]    <= 0;
            conj_m[g] <= inv_i[g];
            zero_m[g] <= 1'b0;
         end
      end
   end

   rd_exp_t er_v, ew_v;
   logic [7:0] bk_v;
   logic distinct_v;

   always @(negedge clk) begin
      for (int g = 0; g < NI; g++) begin
         if (zero_m[g]) begin
            chk("rst_rd_en", g, 64'(o_rd_en[g]), 64'd0);
            chk("rst_wr_en", g, 64'(o_wr_en[g]), 64'd0);
            chk("rst_addr_rd", g, o_addr_rd[g], 64'd0);
            chk("rst_bank_rd", g, 64'(o_bank_rd[g]), 64'd0);
            chk("rst_addr_wr", g, o_addr_wr[g], 64'd0);
            chk("rst_bank_wr", g, 64'(o_bank_wr[g]), 64'd0);
            chk("rst_coef", g, 64'(o_coef[g]), 64'd0);
            chk("rst_bt", g, 64'(o_bt[g]), 64'd0);
            chk("rst_stage", g, 64'(o_stage[g]), 64'd0);
            chk("rst_conj", g, 64'(o_conj[g]), 64'd0);
            chk("rst_done", g, 64'(o_done[g]), 64'd0);
            chk("rst_rdy", g, 64'(o_rdy[g]), 64'd1);
         end else begin
            er_v = busy_m[g] ? model_rd(ln_of(g), t_m[g]) : '0;
            ew_v = busy_m[g] ? model_rd(ln_of(g), t_m[g] - PL) : '0;
            chk("rd_en", g, 64'(o_rd_en[g]), 64'(er_v.en));
            chk("wr_en", g, 64'(o_wr_en[g]), 64'(ew_v.en));
            chk("rdy", g, 64'(o_rdy[g]), 64'(!busy_m[g]));
            chk("done", g, 64'(o_done[g]), 64'(done_m[g]));
            chk("conj", g, 64'(o_conj[g]), 64'(conj_m[g]));
            if (er_v.en) begin
               chk("addr_rd", g, o_addr_rd[g], er_v.addr);
               chk("bank_rd", g, 64'(o_bank_rd[g]), 64'(er_v.bank));
               chk("coef", g, 64'(o_coef[g]), 64'(er_v.coef));
               chk("but_type", g, 64'(o_bt[g]), 64'(er_v.bt));
               chk("stage", g, 64'(o_stage[g]), 64'(er_v.stage));
            end
            if (ew_v.en) begin
               chk("addr_wr", g, o_addr_wr[g], ew_v.addr);
               chk("bank_wr", g, 64'(o_bank_wr[g]), 64'(ew_v.bank));
            end
            if (o_rd_en[g]) begin
               bk_v = o_bank_rd[g];
               distinct_v = (bk_v[1:0] != bk_v[3:2]) && (bk_v[1:0] != bk_v[5:4]) &&
                            (bk_v[1:0] != bk_v[7:6]) && (bk_v[3:2] != bk_v[5:4]) &&
                            (bk_v[3:2] != bk_v[7:6]) && (bk_v[5:4] != bk_v[7:6]);
               chk("bank_distinct", g, 64'(distinct_v), 64'd1);
            end
            // Hand-derived sample points for the small sizes.
            if (busy_m[g] && g == 0 && t_m[g] == 2) begin
               chk("n16_s0b1_addr", g, o_addr_rd[g], 64'hE4);
               chk("n16_s0b1_bank", g, 64'(o_bank_rd[g]), 64'h39);
               chk("n16_s0b1_coef", g, 64'(o_coef[g]), 64'd1);
            end
            if (busy_m[g] && g == 0 && t_m[g] == 12) begin
               chk("n16_s1b1_addr", g, o_addr_rd[g], 64'h55);
               chk("n16_s1b1_bank", g, 64'(o_bank_rd[g]), 64'h39);
               chk("n16_s1b1_coef", g, 64'(o_coef[g]), 64'd0);
            end
            if (busy_m[g] && g == 1 && t_m[g] == 1) begin
               chk("n32_s0b0_addr", g, o_addr_rd[g], 64'hD10);
               chk("n32_s0b0_bank", g, 64'(o_bank_rd[g]), 64'hE4);
            end
            if (busy_m[g] && g == 1 && t_m[g] == 30) begin
               chk("n32_r2b1_addr", g, o_addr_rd[g], 64'h249);
               chk("n32_r2b1_bank", g, 64'(o_bank_rd[g]), 64'h72);
               chk("n32_r2b1_bt", g, 64'(o_bt[g]), 64'd1);
            end
            if (done_m[g]) begin
               chk("done_latency", g, 64'(t_m[g]), 64'(lat_ref(g)));
               $display("inst %0d: transform complete after %0d cycles, conj=%0b", g, t_m[g], o_conj[g]);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic run_full(input int g);
      bit seen;
      @(negedge clk);
      start_i[g] = 1'b1;
      inv_i[g]   = 1'($urandom % 2);
      @(negedge clk);
      start_i[g] = 1'b0;
      seen = 0;
      for (int c = 0; c < 5000 && !seen; c++) begin
         @(negedge clk);
         if (o_done[g]) seen = 1;
         else start_i[g] = ($urandom % 3 == 0);
      end
      start_i[g] = 1'b0;
      if (!seen) chk("done_timeout", g, 64'd0, 64'd1);
   endtask

   initial begin
      rst_n = 1'b0;
      for (int g = 0; g < NI; g++) begin
         start_i[g] = 1'b0;
         abort_i[g] = 1'b0;
         inv_i[g]   = 1'b0;
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int g = 0; g < NI; g++) run_full(g);

      // Abort somewhere in stage 2 of the large transform, then restart.
      @(negedge clk);
      start_i[2] = 1'b1;
      @(negedge clk);
      start_i[2] = 1'b0;
      repeat (2*518 + 1 + $urandom_range(0, 500)) @(negedge clk);
      abort_i[2] = 1'b1;
      @(negedge clk);
      abort_i[2] = 1'b0;
      $display("inst 2: abort issued");
      chk("abort_rd_en", 2, 64'(o_rd_en[2]), 64'd0);
      chk("abort_wr_en", 2, 64'(o_wr_en[2]), 64'd0);
      chk("abort_rdy", 2, 64'(o_rdy[2]), 64'd1);
      repeat (3) @(negedge clk);
      run_full(2);

      // Start together with abort while idle must be ignored.
      start_i[0] = 1'b1;
      abort_i[0] = 1'b1;
      @(negedge clk);
      start_i[0] = 1'b0;
      abort_i[0] = 1'b0;
      chk("idle_start_abort", 0, 64'(o_rdy[0]), 64'd1);
      repeat (2) @(negedge clk);

      // Random start/abort/inverse traffic on the small sizes.
      for (int c = 0; c < 1500; c++) begin
         for (int g = 0; g < 2; g++) begin
            start_i[g] = ($urandom % 8 == 0);
            abort_i[g] = ($urandom % 24 == 0);
            inv_i[g]   = 1'($urandom % 2);
         end
         @(negedge clk);
      end
      for (int g = 0; g < 2; g++) begin
         start_i[g] = 1'b0;
         abort_i[g] = 1'b0;
      end
      repeat (60) @(negedge clk);

      // Inverse transform interrupted by reset.
      inv_i[2]   = 1'b1;
      start_i[2] = 1'b1;
      @(negedge clk);
      start_i[2] = 1'b0;
      inv_i[2]   = 1'b0;
      repeat (300) @(negedge clk);
      chk("inverse_conj", 2, 64'(o_conj[2]), 64'd1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      $display("inst 2: reset issued mid-run");
      repeat (5) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/fft_ctrl_param.md
Name: fft_ctrl_param

Overview:
- Parametrised successor to the fixed 2048-point radix-4 FFT sequencer.
- Drives four single-port-per-leg RAM banks: per-leg read address and bank, delayed in-place write address and bank, twiddle address, butterfly type.
- Supports any power-of-two N. Mixed radix: radix-4 stages, plus one final radix-2 stage when log2(N) is odd.
- Adds explicit enables, start/done handshake, abort, inter-stage drain and inverse-mode flag.

Parameters:
LOG2_N, 11, log2 of transform size N; legal range 4..14; A = LOG2_N-2 is the bank address width.
PIPE_LAT, 5, cycles from read address at ports to the matching result at the write ports; legal range 1..15.

Ports:
iCLK  in  1  clock
iRESET  in  1  reset, synchronous, active-low
iSTART  in  1  start request; sampled only in IDLE
iABORT  in  1  abandon the current transform
iINVERSE  in  1  inverse FFT request; latched on accepted iSTART
oRD_EN  out  1  read addresses valid this cycle
oADDR_RD  out  4*A  leg m address at bits [m*A +: A]
oBANK_RD  out  8  leg m bank at bits [2m +: 2]
oWR_EN  out  1  write addresses valid
oADDR_WR  out  4*A  write address per leg
oBANK_WR  out  8  write bank per leg
oADDR_COEF  out  A  twiddle base index; datapath scales it by leg m
oBUT_TYPE  out  1  0 = one radix-4 butterfly, 1 = two radix-2 butterfly pairs (legs 0/1, 2/3)
oSTAGE  out  4  current stage number
oCONJ  out  1  latched iINVERSE
oRDY  out  1  idle, able to accept iSTART
oDONE  out  1  one-cycle pulse when the transform completes

Behaviour:
- Reset: every output is 0 except oRDY = 1. State is IDLE.
- Stage count:
  - R4 = floor(LOG2_N/2) radix-4 stages.
  - When LOG2_N is odd, one extra radix-2 stage follows; STAGES = R4 + (LOG2_N mod 2).
- States and transitions:
  - IDLE: iSTART=1 and iABORT=0 -> RUN, stage 0, b = 0, oRDY = 0.
  - RUN: butterfly counter b steps 0..N/4-1, one per cycle. At b = N/4-1 -> GAP.
  - GAP: lasts PIPE_LAT+1 cycles with oRD_EN = 0. Guarantees the last write of a stage lands before the next stage's first read. Then either the next stage enters RUN, or, after the last stage, IDLE with a one-cycle oDONE pulse and oRDY = 1 on the same cycle.
- Output timing: addresses are registered. The outputs for b appear one cycle after b is issued; oRD_EN is aligned with them.
- Total latency: from the iSTART sampling edge to oDONE is exactly STAGES*(N/4 + PIPE_LAT + 1) + 1 cycles.
- Index generation, radix-4 stage s:
  - Span S = 2^(LOG2_N-2-2s).
  - base = (b div S)*4S + (b mod S).
  - Leg m index i_m = base + m*S.
  - oADDR_COEF = (b mod S) << 2s.
- Index generation, radix-2 stage: i_m = 4b + m; oADDR_COEF = 0.
- Bank mapping (conflict-free):
  - Address = i >> 2.
  - c = LOG2_N mod 2. Digits d_k = i[2k+c+1 : 2k+c].
  - bank(i) = (sum of d_k + 2*c*i[0]) mod 4.
- Write side: oWR_EN, oADDR_WR and oBANK_WR are exact copies of the read-side outputs delayed by PIPE_LAT cycles. The delay line continues to drain through GAP.
- oSTAGE and oBUT_TYPE are aligned with the read outputs.
- oCONJ is held from accepted iSTART until the next accepted iSTART.
- Boundary conditions:
  - iSTART while not IDLE: ignored.
  - iABORT in any non-IDLE state: next cycle IDLE, delay line flushed, all enables 0, oRDY = 1, no oDONE.
  - iABORT together with iSTART in IDLE: iSTART ignored.
  - iRESET low mid-transform: same result as abort, plus outputs returned to reset values.
  - b wrap: b returns to 0 at each stage boundary.
  - oADDR_COEF arithmetic is modulo 2^A; no overflow is possible for legal b.

Decomposition:
- Package fft_ctrl_pkg holds:
  - state enum {IDLE, RUN, GAP};
  - functions num_stages(LOG2_N) and bank_of(index, LOG2_N);
  - defaults for LOG2_N and PIPE_LAT.
- Sub-module fft_ctrl_delay: a PIPE_LAT-deep shift register carrying {en, 4 addresses, 4 banks}, with a synchronous flush input.

Test Plan:
1. LOG2_N=4, PIPE_LAT=5, pulse iSTART -> stage 0 b=1: addresses {0,1,2,3}, banks {1,2,3,0}, coef 1. Stage 1 b=1: addresses {1,1,1,1}, banks {1,2,3,0}, coef 0. oDONE exactly 21 cycles after the start edge.
2. LOG2_N=5 -> 3 stages. Stage 0 b=0: addresses {0,2,4,6}, banks {0,1,2,3}. Radix-2 stage b=1: addresses {1,1,1,1}, banks {2,0,3,1}, oBUT_TYPE = 1.
3. LOG2_N=11 -> 6 stages. oDONE at cycle 3109. Every cycle with oRD_EN = 1 has four distinct banks. oWR_EN trails oRD_EN by exactly 5 cycles.
4. iABORT mid-stage 2 -> next cycle oRD_EN = oWR_EN = 0 and oRDY = 1, no oDONE. A following iSTART restarts at stage 0, b = 0.
5. iSTART repeated while busy -> ignored, completion timing unchanged. iSTART together with iABORT in IDLE -> stays IDLE.
6. iINVERSE=1 at start -> oCONJ = 1 for the whole transform. Synchronous iRESET low mid-run -> all outputs at reset values on the next edge.
